drawing_rect_fill: RTL and testbench

Active rectangle-fill engine that occupies the drawing-function slot in place of the tie-off cell. Same command interface: `req`/`ack`/`busy` plus parameter registers `r0`–`r7`. On a command it walks a clipped rectangle of 8-bit pixels in the frame buffer and issues word-wide, byte-masked transfers on the `de_*` bus. Two modes are supported: solid fill (write only) and XOR (read-modify-write).

---
 rtl/drawing_rect_fill_pkg.sv | 29 ++
 rtl/drawing_rect_fill_span_gen.sv | 20 ++
 rtl/drawing_rect_fill.sv | 165 ++++++++++++++++
 tb/tb_drawing_rect_fill.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/drawing_rect_fill_pkg.sv
// Shared types, constants and lane-mask helpers for the rectangle-fill engine.
package drawing_pkg;
  localparam int IDX_W  = 20;
  localparam int IDX2_W = IDX_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_STEP} state_e;

  localparam logic       MODE_SOLID = 1'b0;
  localparam logic       MODE_XOR   = 1'b1;
  localparam logic [3:0] NBYTE_IDLE = 4'b1111;

  // Active-low enable: lane k is on when its pixel lies in [row_base+x0, row_base+x1).
  function automatic logic [3:0] lane_mask(input logic [IDX_W-1:0] word, input logic [15:0] x0,
                                           input logic [16:0] x1, input logic [IDX_W-1:0] row_base);
    logic [IDX2_W-1:0] lo, hi, p;
    lane_mask = NBYTE_IDLE;
    lo = {2'b00, row_base} + IDX2_W'(x0);
    hi = {2'b00, row_base} + IDX2_W'(x1);
    for (int k = 0; k < 4; k++) begin
      p = {word, 2'b00} + IDX2_W'(k);
      if (p >= lo && p < hi) lane_mask[k] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] lane_data(input logic [3:0] nbyte, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      lane_data[8*k +: 8] = nbyte[k] ? 8'h00 : d[8*k +: 8];
  endfunction
endpackage

// File: rtl/drawing_rect_fill_span_gen.sv
// Word range of one clipped row and the byte mask of a selected word in it.
module drawing_span_gen
  import drawing_pkg::*;
(
  input  logic [15:0]      x0_i,
  input  logic [16:0]      x1_i,
  input  logic [IDX_W-1:0] row_base_i,
  input  logic [IDX_W-1:0] word_i,
  output logic [IDX_W-1:0] ws_o,
  output logic [IDX_W-1:0] we_o,
  output logic [3:0]       nbyte_o
);
  logic [IDX_W-1:0] first_px, last_px;

  assign first_px = row_base_i + IDX_W'(x0_i);
  assign last_px  = row_base_i + IDX_W'(x1_i) - IDX_W'(1);
  assign ws_o     = first_px >> 2;
  assign we_o     = last_px >> 2;
  assign nbyte_o  = lane_mask(word_i, x0_i, x1_i, row_base_i);
endmodule

// File: rtl/drawing_rect_fill.sv
// Rectangle-fill drawing engine: clips a rectangle and walks it as byte-masked word transfers.
module drawing_rect_fill
  import drawing_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 18,
  parameter int BASE     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  input  logic [15:0]       r0,
  input  logic [15:0]       r1,
  input  logic [15:0]       r2,
  input  logic [15:0]       r3,
  input  logic [15:0]       r4,
  input  logic [15:0]       r5,
  input  logic [15:0]       r6,
  input  logic [15:0]       r7,
  output logic              de_req,
  input  logic              de_ack,
  output logic [ADDR_W-1:0] de_addr,
  output logic [3:0]        de_nbyte,
  output logic              de_rnw,
  output logic [31:0]       de_w_data,
  input  logic [31:0]       de_r_data
);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  state_e            state_q, state_d;
  logic              ack_q, ack_d, busy_q, busy_d, mode_q, mode_d;
  logic [15:0]       x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d, row_q, row_d;
  logic [7:0]        colour_q, colour_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [31:0]       rd_q, rd_d;
  logic              de_req_q, de_req_d, de_rnw_q, de_rnw_d;
  logic [3:0]        de_nbyte_q, de_nbyte_d;
  logic [ADDR_W-1:0] de_addr_q, de_addr_d;
  logic [31:0]       de_w_data_q, de_w_data_d;

  logic [16:0]       x1_sum, y1_sum, x1, y1;
  logic              empty, last_word, last_row, issue, bus_clr, done;
  logic [IDX_W-1:0]  row_base, ws, we, mask_word, issue_word;
  logic [3:0]        mask;
  logic [31:0]       fill;
  logic              unused_inputs;

  assign unused_inputs = ^{r4[15:8], r5[15:1], r6, r7};

  // 17-bit sums so a large origin plus extent cannot wrap back on-screen
  assign x1_sum = {1'b0, x0_q} + {1'b0, w_q};
  assign y1_sum = {1'b0, y0_q} + {1'b0, h_q};
  assign x1     = (x1_sum > 17'(SCREEN_W)) ? 17'(SCREEN_W) : x1_sum;
  assign y1     = (y1_sum > 17'(SCREEN_H)) ? 17'(SCREEN_H) : y1_sum;
  assign empty  = ({1'b0, x0_q} >= x1) || ({1'b0, y0_q} >= y1);

  assign row_base   = IDX_W'(row_q) * IDX_W'(SCREEN_W);
  assign last_word  = (word_q == we);
  assign last_row   = (({1'b0, row_q} + 17'd1) == y1);
  assign done       = empty || (last_word && last_row);
  assign issue_word = (state_q == S_SETUP) ? ws : word_q + IDX_W'(1);
  assign mask_word  = (state_q == S_SETUP || state_q == S_STEP) ? issue_word : word_q;
  assign issue      = !empty && ((state_q == S_SETUP) || (state_q == S_STEP && !last_word));
  assign fill       = {4{colour_q}};

  drawing_span_gen u_span (
    .x0_i      (x0_q),
    .x1_i      (x1),
    .row_base_i(row_base),
    .word_i    (mask_word),
    .ws_o      (ws),
    .we_o      (we),
    .nbyte_o   (mask)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_SETUP;
      S_SETUP: state_d = empty ? S_STEP : ((mode_q == MODE_XOR) ? S_READ : S_WRITE);
      S_READ:  if (de_req_q && de_ack) state_d = S_WRITE;
      S_WRITE: if (de_req_q && de_ack) state_d = S_STEP;
      S_STEP: begin
        if (done)           state_d = S_IDLE;
        else if (last_word) state_d = S_SETUP;
        else                state_d = (mode_q == MODE_XOR) ? S_READ : S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;  busy_d = busy_q;  mode_d = mode_q;  colour_d = colour_q;
    x0_d = x0_q;  y0_d = y0_q;  w_d = w_q;  h_d = h_q;  row_d = row_q;
    word_d = word_q;  rd_d = rd_q;  bus_clr = 1'b0;
    de_req_d = de_req_q;  de_rnw_d = de_rnw_q;  de_nbyte_d = de_nbyte_q;
    de_addr_d = de_addr_q;  de_w_data_d = de_w_data_q;
    case (state_q)
      S_IDLE: if (req) begin
        ack_d = 1'b1;  busy_d = 1'b1;
        x0_d = r0;  y0_d = r1;  w_d = r2;  h_d = r3;  row_d = r1;
        colour_d = r4[7:0];  mode_d = r5[0];
      end
      S_READ: if (de_req_q && de_ack) begin
        rd_d = de_r_data;  bus_clr = 1'b1;
      end
      S_WRITE: begin
        // XOR writes arrive here with the bus released after the read
        if (!de_req_q) begin
          de_req_d = 1'b1;  de_rnw_d = 1'b0;  de_nbyte_d = mask;
          de_addr_d = BASE_A + ADDR_W'(word_q);
          de_w_data_d = lane_data(mask, rd_q ^ fill);
        end else if (de_ack) bus_clr = 1'b1;
      end
      S_STEP: begin
        if (done)           busy_d = 1'b0;
        else if (last_word) row_d = row_q + 16'd1;
      end
      default: ;
    endcase
    if (issue) begin
      word_d = issue_word;  de_req_d = 1'b1;
      de_addr_d = BASE_A + ADDR_W'(issue_word);
      if (mode_q == MODE_XOR) begin
        de_rnw_d = 1'b1;  de_nbyte_d = 4'b0000;  de_w_data_d = 32'h0;
      end else begin
        de_rnw_d = 1'b0;  de_nbyte_d = mask;  de_w_data_d = lane_data(mask, fill);
      end
    end
    if (bus_clr) begin
      de_req_d = 1'b0;  de_rnw_d = 1'b1;  de_nbyte_d = NBYTE_IDLE;
      de_addr_d = '0;   de_w_data_d = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_q <= 1'b0;  busy_q <= 1'b0;  mode_q <= MODE_SOLID;  colour_q <= 8'h0;
      x0_q <= '0;  y0_q <= '0;  w_q <= '0;  h_q <= '0;  row_q <= '0;
      word_q <= '0;  rd_q <= '0;
      de_req_q <= 1'b0;  de_rnw_q <= 1'b1;  de_nbyte_q <= NBYTE_IDLE;
      de_addr_q <= '0;  de_w_data_q <= '0;
    end else begin
      ack_q <= ack_d;  busy_q <= busy_d;  mode_q <= mode_d;  colour_q <= colour_d;
      x0_q <= x0_d;  y0_q <= y0_d;  w_q <= w_d;  h_q <= h_d;  row_q <= row_d;
      word_q <= word_d;  rd_q <= rd_d;
      de_req_q <= de_req_d;  de_rnw_q <= de_rnw_d;  de_nbyte_q <= de_nbyte_d;
      de_addr_q <= de_addr_d;  de_w_data_q <= de_w_data_d;
    end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign de_req    = de_req_q;
  assign de_rnw    = de_rnw_q;
  assign de_nbyte  = de_nbyte_q;
  assign de_addr   = de_addr_q;
  assign de_w_data = de_w_data_q;
endmodule

// File: tb/tb_drawing_rect_fill.sv
// Bench for drawing_rect_fill: pixel-level model feeds a transfer scoreboard checked by a bus responder.
module tb_drawing_rect_fill;
  localparam int SW = 640, SH = 480, AW = 18;

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic ack, busy, de_req, de_rnw;
  logic [15:0] r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0, r6 = 16'hDEAD, r7 = 16'hBEEF;
  logic de_ack = 1'b0;
  logic [AW-1:0] de_addr;
  logic [3:0] de_nbyte;
  logic [31:0] de_w_data, de_r_data = '0;

  always #5 clk = ~clk;

  drawing_rect_fill #(.SCREEN_W(SW), .SCREEN_H(SH), .ADDR_W(AW), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
  );

  typedef struct { logic rnw; int addr; logic [3:0] nb; logic [31:0] wd; } xfer_t;
  typedef struct {
    int x0, y0, w, h; logic [7:0] c; logic m;
    int n_wr; int fa; logic [3:0] fnb; logic [31:0] fwd; bit cwd; int bcyc;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  tv[9];
  int n_cmp = 0, n_bad = 0;
  int dly_lo = 0, dly_hi = 0;
  bit spur = 1'b0;
  int n_wr = 0, first_addr = 0;
  logic [3:0] first_nb;
  logic [31:0] first_wd;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdf(input int a);
    return 32'h12345678 ^ (32'(a - 1) * 32'h9E3779B1);
  endfunction

  // Reference: enumerate clipped pixels per row, group them into words.
  task automatic push_model(input int x0, y0, w, h, input logic [7:0] c, input logic m);
    int x1, y1, s, e;
    logic [3:0] nb;
    logic [31:0] d;
    x1 = (x0 + w > SW) ? SW : x0 + w;
    y1 = (y0 + h > SH) ? SH : y0 + h;
    if (x0 >= x1 || y0 >= y1) return;
    for (int y = y0; y < y1; y++) begin
      s = y * SW + x0;
      e = y * SW + x1 - 1;
      for (int wd = s / 4; wd <= e / 4; wd++) begin
        nb = 4'hF;
        for (int k = 0; k < 4; k++) if (wd * 4 + k >= s && wd * 4 + k <= e) nb[k] = 1'b0;
        d = m ? (rdf(wd) ^ {4{c}}) : {4{c}};
        for (int k = 0; k < 4; k++) if (nb[k]) d[8*k +: 8] = 8'h00;
        if (m) exp_q.push_back('{1'b1, wd, 4'h0, 32'h0});
        exp_q.push_back('{1'b0, wd, nb, d});
      end
    end
  endtask

  task automatic score();
    xfer_t e;
    chk("xfer_expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("xfer", {de_rnw, de_addr, de_nbyte, de_rnw ? 32'h0 : de_w_data},
        {e.rnw, AW'(e.addr), e.nb, e.rnw ? 32'h0 : e.wd});
    if (!de_rnw) begin
      n_wr++;
      if (n_wr == 1) begin first_addr = int'(de_addr); first_nb = de_nbyte; first_wd = de_w_data; end
    end
  endtask

  // Bus responder: random ack delay, stability check while waiting, stray acks when idle.
  int dly = -1;
  logic [54:0] snap;
  always @(negedge clk) begin
    if (!rst_n) begin
      de_ack = 1'b0;  dly = -1;
    end else if (de_req) begin
      if (dly < 0) begin
        dly = int'($urandom_range(dly_hi, dly_lo));
        snap = {de_rnw, de_addr, de_nbyte, de_w_data};
      end else chk("stable", {de_rnw, de_addr, de_nbyte, de_w_data}, snap);
      if (dly == 0) begin
        de_ack = 1'b1;  dly = -1;
        if (de_rnw) de_r_data = rdf(int'(de_addr));
        score();
      end else begin
        de_ack = 1'b0;  dly--;
      end
    end else de_ack = spur && ($urandom_range(2, 0) == 0);
  end

  task automatic run_cmd(input int x0, y0, w, h, input logic [7:0] c, input logic m, input bit hold,
                         output int bcyc, output int nack, output bit tmo);
    exp_q.delete();
    push_model(x0, y0, w, h, c, m);
    n_wr = 0;  bcyc = 0;  nack = 0;  tmo = 1'b1;
    @(negedge clk);
    r0 = 16'(x0);  r1 = 16'(y0);  r2 = 16'(w);  r3 = 16'(h);
    r4 = {8'h5C, c};  r5 = {15'h7FFE, m};  req = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (ack) nack++;
      if (!busy) begin tmo = 1'b0; break; end
      bcyc++;
      if (!hold) req = 1'b0;
    end
    req = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, na, x0, y0, w, h;
    bit tmo;
    tv[0] = '{0,   0,   8,  2, 8'hA5, 1'b0, 4,  0,     4'b0000, 32'hA5A5A5A5, 1'b1, 10};
    tv[1] = '{3,   1,   6,  1, 8'h5A, 1'b0, 3,  160,   4'b0111, 32'h5A000000, 1'b1, 7};
    tv[2] = '{4,   0,   4,  1, 8'h0F, 1'b1, 1,  1,     4'b0000, 32'h1D3B5977, 1'b1, 5};
    tv[3] = '{638, 479, 10, 5, 8'hC3, 1'b0, 1,  76799, 4'b0011, 32'hC3C30000, 1'b1, 3};
    tv[4] = '{700, 0,   4,  1, 8'h11, 1'b0, 0,  0,     4'b0000, 32'h0,        1'b0, 2};
    tv[5] = '{5,   10,  13, 3, 8'h3C, 1'b0, 12, 1601,  4'b0001, 32'h3C3C3C00, 1'b1, 27};
    tv[6] = '{1,   2,   2,  2, 8'hFF, 1'b1, 2,  320,   4'b1001, 32'h0,        1'b0, 10};
    tv[7] = '{0,   0,   0,  4, 8'h77, 1'b0, 0,  0,     4'b0000, 32'h0,        1'b0, 2};
    tv[8] = '{10,  480, 4,  1, 8'h22, 1'b0, 0,  0,     4'b0000, 32'h0,        1'b0, 2};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {ack, busy, de_req, de_rnw, de_nbyte, de_addr, de_w_data},
        {1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 18'h0, 32'h0});
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait table: exact transfer lists plus busy length
    foreach (tv[i]) begin
      run_cmd(tv[i].x0, tv[i].y0, tv[i].w, tv[i].h, tv[i].c, tv[i].m, 1'b0, bc, na, tmo);
      chk($sformatf("v%0d_timeout", i), 64'(tmo), 64'd0);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(tv[i].bcyc));
      chk($sformatf("v%0d_ack_pulses", i), 64'(na), 64'd1);
      chk($sformatf("v%0d_writes", i), 64'(n_wr), 64'(tv[i].n_wr));
      chk($sformatf("v%0d_drained", i), 64'(exp_q.size()), 64'd0);
      if (tv[i].n_wr > 0) begin
        chk($sformatf("v%0d_first_addr", i), 64'(first_addr), 64'(tv[i].fa));
        chk($sformatf("v%0d_first_nbyte", i), 64'(first_nb), 64'(tv[i].fnb));
        if (tv[i].cwd) chk($sformatf("v%0d_first_wdata", i), 64'(first_wd), 64'(tv[i].fwd));
      end
    end

    // Handshake stress: random ack delays, stray acks, req held through busy
    dly_lo = 0;  dly_hi = 5;  spur = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x0 = int'($urandom_range(660, 0));  y0 = int'($urandom_range(485, 470));
      w = int'($urandom_range(20, 0));    h = int'($urandom_range(4, 0));
      if (i < 4) y0 = int'($urandom_range(100, 0));
      run_cmd(x0, y0, w, h, 8'($urandom), 1'($urandom), 1'b1, bc, na, tmo);
      chk($sformatf("s%0d_timeout", i), 64'(tmo), 64'd0);
      chk($sformatf("s%0d_ack_pulses", i), 64'(na), 64'd1);
      chk($sformatf("s%0d_drained", i), 64'(exp_q.size()), 64'd0);
    end

    // Async reset while a transfer is outstanding
    dly_lo = 8;  dly_hi = 8;  spur = 1'b0;
    exp_q.delete();
    push_model(0, 0, 8, 2, 8'hA5, 1'b0);
    @(negedge clk);
    r0 = 16'd0;  r1 = 16'd0;  r2 = 16'd8;  r3 = 16'd2;  r4 = 16'h00A5;  r5 = 16'h0;  req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      if (de_req) break;
    end
    chk("rst_seq_de_req_high", 64'(de_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {ack, busy, de_req, de_rnw, de_nbyte, de_addr, de_w_data},
           {1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 18'h0, 32'h0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dly_lo = 0;  dly_hi = 2;
    run_cmd(3, 1, 6, 1, 8'h5A, 1'b0, 1'b0, bc, na, tmo);
    chk("post_reset_timeout", 64'(tmo), 64'd0);
    chk("post_reset_ack", 64'(na), 64'd1);
    chk("post_reset_writes", 64'(n_wr), 64'd3);
    chk("post_reset_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
